lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//  Sequences load/store accesses issued by the decoded memory stage onto the data-memory (DM) and UART ports.
//  Decodes each address to a target and raises cs_dm or cs_uart.
//  Stalls the pipeline for multi-cycle accesses, formats load data and store byte masks, and flags faults.
//  Sits between the execute/memory stage and the DM/UART slaves.
// PARAMETERS
//  DM_BASE      32'h0000_0000  DM window base address
//  DM_SIZE      32'h0000_1000  DM window size in bytes (power of 2)
//  UART_BASE    32'h8000_0000  UART window base address (16-byte window)
//  UART_TIMEOUT 255            max UART wait cycles before fault (>=1)
// PORTS
//  clk         in   1   core clock
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   memory op present (load or store opcode)
//  req_we      in   1   1=store, 0=load
//  req_addr    in   32  byte address (ALU result)
//  req_wdata   in   32  store data (rs2)
//  req_funct3  in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  stall       out  1   hold PC/pipeline regs; request stays stable while 1
//  resp_valid  out  1   access complete this cycle
//  resp_rdata  out  32  formatted load data (0 for stores/faults)
//  fault       out  1   misaligned/unmapped/timeout, valid with resp_valid
//  cs_dm       out  1   DM select
//  dm_we       out  1   DM write enable
//  dm_addr     out  32  word address (req_addr - DM_BASE, [1:0]=0)
//  dm_wdata    out  32  lane-replicated store data
//  dm_mask     out  4   byte write strobes
//  dm_rdata    in   32  DM read data, valid 1 cycle after cs_dm & !dm_we
//  cs_uart     out  1   UART select
//  uart_we     out  1   UART write enable
//  uart_addr   out  4   req_addr[3:0]
//  uart_wdata  out  32  req_wdata unmodified
//  uart_ready  in   1   UART completes access this cycle
//  uart_rdata  in   32  UART read data, valid with uart_ready
// BEHAVIOUR
//  Reset: state=IDLE, counter=0; all outputs 0, asynchronous on rst_n fall.
//  Reset mid-access aborts it; no response is produced.
//  FSM states: IDLE, DM_RD, UART_WAIT.
//  Fault check in IDLE, evaluated first:
//   - H/HU with addr[0]!=0, or W with addr[1:0]!=0, or address in neither window.
//   - Response: resp_valid=1, fault=1, rdata=0, no chip select, no stall; stay IDLE.
//   - funct3 011/110/111 is treated as unmapped -> fault.
//  DM store:
//   - IDLE, same cycle: cs_dm=1, dm_we=1, resp_valid=1, stall=0.
//   - Masks: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
//   - dm_wdata: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
//  DM load:
//   - Cycle 0: cs_dm=1, dm_we=0, stall=1, goto DM_RD.
//   - Cycle 1 (DM_RD): resp_valid=1, stall=0, goto IDLE.
//   - Load latency is 1 stall cycle.
//   - resp_rdata: select byte/half by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
//  UART access (load or store):
//   - IDLE -> UART_WAIT with cs_uart=1 and stall=1 from cycle 0.
//   - cs_uart and uart_we held until completion; counter increments each cycle.
//   - Completion on uart_ready=1: resp_valid=1, stall=0, resp_rdata=uart_rdata (loads, no formatting), goto IDLE.
//   - uart_ready in the very first cycle also completes in that cycle (0 stall).
//   - Timeout when counter==UART_TIMEOUT with no ready: resp_valid=1, fault=1, rdata=0, cs_uart drops, goto IDLE.
//   - uart_ready and timeout in the same cycle: ready wins, no fault.
//  Response timing:
//   - stall and cs_* are combinational from state+request.
//   - resp_* are valid in the completion cycle only.
//   - A new request is accepted the cycle after completion; back-to-back requests are supported.
//  req_valid=0 in IDLE: all outputs 0.
//  Pipeline flush (req_valid drop) in DM_RD/UART_WAIT is illegal; the bench asserts against it.
// TESTING
//  1 SW addr 0x10 data 0xDEADBEEF -> same cycle cs_dm=1 dm_we=1 mask=1111 dm_addr=0x10 resp_valid=1, stall=0.
//  2 SB addr 0x13 data 0xA5 -> mask=1000, dm_wdata=0xA5A5A5A5.
//    Then LB addr 0x13 with dm_rdata=0xA5000000 -> stall 1 cycle, resp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
//  3 LH addr 0x11 -> fault=1, resp_valid=1, cs_dm=0, no stall.
//    LW addr 0x4000_0000 -> fault (unmapped).
//  4 SW to 0x8000_0004, uart_ready after 3 cycles -> stall 3 cycles, cs_uart/uart_we held, completes with no fault.
//  5 LW 0x8000_0000 with uart_ready never asserted, TIMEOUT=4 -> fault pulse after 4 wait cycles, rdata=0, back to IDLE.
//  6 rst_n low during UART_WAIT -> cs_uart/stall drop immediately, no resp_valid.
//    Next LW after reset completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: decodes each memory-stage access to the DM or UART window,
// stalls for multi-cycle accesses, formats load data / store strobes and flags faults.
module lsu_bus_ctrl #(
  parameter logic [31:0] DM_BASE      = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE      = 32'h0000_1000,
  parameter logic [31:0] UART_BASE    = 32'h8000_0000,
  parameter int          UART_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_fault,
  output logic        o_cs_dm,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  output logic [3:0]  o_dm_mask,
  input  logic [31:0] i_dm_rdata,
  output logic        o_cs_uart,
  output logic        o_uart_we,
  output logic [3:0]  o_uart_addr,
  output logic [31:0] o_uart_wdata,
  input  logic        i_uart_ready,
  input  logic [31:0] i_uart_rdata,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(UART_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DM_RD     = 2'd1,
    S_UART_WAIT = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;

  logic        w_active;
  logic [31:0] w_off;
  logic        w_in_dm;
  logic        w_in_uart;
  logic        w_misal;
  logic        w_bad_f3;
  logic        w_fault_req;
  logic        w_cnt_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_dm_load;
  logic [31:0] w_dm_wdata;
  logic [3:0]  w_dm_mask;

  // Reset gates the combinational outputs too, so an aborted access vanishes at once.
  assign w_active    = rst_n & i_req_valid;
  assign w_off       = i_req_addr - DM_BASE;
  assign w_in_dm     = (w_off < DM_SIZE);
  assign w_in_uart   = (i_req_addr[31:4] == UART_BASE[31:4]);
  assign w_bad_f3    = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                       (i_req_funct3 == 3'b111);
  assign w_misal     = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign w_fault_req = w_bad_f3 || w_misal || !(w_in_dm || w_in_uart);
  assign w_cnt_done  = (r_cnt == CW'(UART_TIMEOUT));
  assign o_dbg_state = r_state;

  always_comb begin
    w_byte = i_dm_rdata[7:0];
    case (i_req_addr[1:0])
      2'd1:    w_byte = i_dm_rdata[15:8];
      2'd2:    w_byte = i_dm_rdata[23:16];
      2'd3:    w_byte = i_dm_rdata[31:24];
      default: w_byte = i_dm_rdata[7:0];
    endcase
    w_half = i_req_addr[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];
    case (i_req_funct3)
      3'b000:  w_dm_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_dm_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_dm_load = {24'd0, w_byte};
      3'b101:  w_dm_load = {16'd0, w_half};
      default: w_dm_load = i_dm_rdata;
    endcase
    case (i_req_funct3[1:0])
      2'b00: begin
        w_dm_mask  = 4'b0001 << i_req_addr[1:0];
        w_dm_wdata = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        w_dm_mask  = 4'b0011 << {i_req_addr[1], 1'b0};
        w_dm_wdata = {2{i_req_wdata[15:0]}};
      end
      default: begin
        w_dm_mask  = 4'b1111;
        w_dm_wdata = i_req_wdata;
      end
    endcase
  end

  always_comb begin
    o_stall      = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_rdata = 32'd0;
    o_fault      = 1'b0;
    o_cs_dm      = 1'b0;
    o_dm_we      = 1'b0;
    o_dm_addr    = 32'd0;
    o_dm_wdata   = 32'd0;
    o_dm_mask    = 4'd0;
    o_cs_uart    = 1'b0;
    o_uart_we    = 1'b0;
    o_uart_addr  = 4'd0;
    o_uart_wdata = 32'd0;
    if (w_active) begin
      case (r_state)
        S_IDLE: begin
          if (w_fault_req) begin
            o_resp_valid = 1'b1;
            o_fault      = 1'b1;
          end else if (w_in_dm) begin
            o_cs_dm   = 1'b1;
            o_dm_we   = i_req_we;
            o_dm_addr = {w_off[31:2], 2'b00};
            if (i_req_we) begin
              o_dm_wdata   = w_dm_wdata;
              o_dm_mask    = w_dm_mask;
              o_resp_valid = 1'b1;
            end else begin
              o_stall = 1'b1;
            end
          end else begin
            o_cs_uart    = 1'b1;
            o_uart_we    = i_req_we;
            o_uart_addr  = i_req_addr[3:0];
            o_uart_wdata = i_req_wdata;
            if (i_uart_ready) begin
              o_resp_valid = 1'b1;
              o_resp_rdata = i_req_we ? 32'd0 : i_uart_rdata;
            end else begin
              o_stall = 1'b1;
            end
          end
        end
        S_DM_RD: begin
          o_resp_valid = 1'b1;
          o_resp_rdata = w_dm_load;
        end
        S_UART_WAIT: begin
          // Ready outranks the timeout; on timeout the select is withdrawn.
          if (i_uart_ready || !w_cnt_done) begin
            o_cs_uart    = 1'b1;
            o_uart_we    = i_req_we;
            o_uart_addr  = i_req_addr[3:0];
            o_uart_wdata = i_req_wdata;
          end
          if (i_uart_ready) begin
            o_resp_valid = 1'b1;
            o_resp_rdata = i_req_we ? 32'd0 : i_uart_rdata;
          end else if (w_cnt_done) begin
            o_resp_valid = 1'b1;
            o_fault      = 1'b1;
          end else begin
            o_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_req_valid && !w_fault_req) begin
            if (w_in_dm) begin
              if (!i_req_we) r_state <= S_DM_RD;
            end else if (!i_uart_ready) begin
              r_state <= S_UART_WAIT;
              r_cnt   <= CW'(1);
            end
          end
        end
        S_DM_RD: r_state <= S_IDLE;
        S_UART_WAIT: begin
          if (i_uart_ready || w_cnt_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed DM/UART/fault/reset cases plus random DM traffic,
// with expected responses queued at issue and compared when resp_valid appears.
module tb_lsu_bus_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic        cs_dm;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_mask;
  logic [31:0] dm_rdata;
  logic        cs_uart;
  logic        uart_we;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_ready;
  logic [31:0] uart_rdata;
  logic [1:0]  dbg_state;

  lsu_bus_ctrl #(
    .DM_BASE     (32'h0000_0000),
    .DM_SIZE     (32'h0000_1000),
    .UART_BASE   (32'h8000_0000),
    .UART_TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_funct3(req_funct3),
    .o_stall     (stall),
    .o_resp_valid(resp_valid),
    .o_resp_rdata(resp_rdata),
    .o_fault     (fault),
    .o_cs_dm     (cs_dm),
    .o_dm_we     (dm_we),
    .o_dm_addr   (dm_addr),
    .o_dm_wdata  (dm_wdata),
    .o_dm_mask   (dm_mask),
    .i_dm_rdata  (dm_rdata),
    .o_cs_uart   (cs_uart),
    .o_uart_we   (uart_we),
    .o_uart_addr (uart_addr),
    .o_uart_wdata(uart_wdata),
    .i_uart_ready(uart_ready),
    .i_uart_rdata(uart_rdata),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A request must not be withdrawn while the controller is mid-access.
  always @(posedge clk) begin
    if (rst_n && dbg_state != 2'd0)
      assert (req_valid) else $error("req_valid dropped during access");
  end

  // scoreboard
  logic [32:0] exp_q[$];
  int total;
  int bad;

  // first-cycle and completion-cycle snapshots from the last access
  logic        f_cs_dm, f_dm_we, f_cs_uart, f_uart_we, e_cs_uart, held_ok;
  logic [31:0] f_dm_addr, f_dm_wdata, f_uart_wdata;
  logic [3:0]  f_dm_mask, f_uart_addr;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // driver: called 1 time unit after a rising edge; returns 1 time unit after a rising edge
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] dm_rd, input logic [31:0] uart_rd,
                         input int uart_lat, input int exp_stalls,
                         input logic exp_fault, input logic [31:0] exp_rdata);
    logic done;
    logic [32:0] e;
    exp_q.push_back({exp_fault, exp_rdata});
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    dm_rdata   = dm_rd;
    uart_rdata = uart_rd;
    done       = 1'b0;
    held_ok    = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      uart_ready = (c == uart_lat);
      #4;
      if (c == 0) begin
        f_cs_dm      = cs_dm;
        f_dm_we      = dm_we;
        f_dm_addr    = dm_addr;
        f_dm_wdata   = dm_wdata;
        f_dm_mask    = dm_mask;
        f_cs_uart    = cs_uart;
        f_uart_we    = uart_we;
        f_uart_addr  = uart_addr;
        f_uart_wdata = uart_wdata;
      end
      if (resp_valid) begin
        e = exp_q.pop_front();
        check({tag, "/resp"}, {fault, resp_rdata}, e);
        check({tag, "/stalls"}, 33'(c), 33'(exp_stalls));
        check({tag, "/stall_lo"}, {32'd0, stall}, 33'd0);
        e_cs_uart = cs_uart;
        done = 1'b1;
      end else begin
        check({tag, "/stall_hi"}, {32'd0, stall}, 33'd1);
        if (c > 0 && !(cs_uart && uart_we == we)) held_ok = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    uart_ready = 1'b0;
    if (!done) begin
      check({tag, "/no_resp"}, 33'd0, 33'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle_check(input string tag);
    req_valid = 1'b0;
    #4;
    check(tag, {1'b0, stall, resp_valid, fault, cs_dm, dm_we, cs_uart, uart_we,
                (|resp_rdata), (|dm_addr), (|dm_wdata), (|dm_mask), (|uart_addr),
                (|uart_wdata), 20'd0}, 33'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h8000_0000;
    req_wdata  = 32'd0;
    req_funct3 = 3'b010;
    dm_rdata   = 32'd0;
    uart_ready = 1'b0;
    uart_rdata = 32'd0;

    // reset: outputs quiet even with a request present
    repeat (3) @(posedge clk);
    #1;
    check("rst/outs", {29'd0, cs_uart, stall, resp_valid, cs_dm}, 33'd0);
    check("rst/state", {31'd0, dbg_state}, 33'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_check("idle/outs");

    // DM stores
    run_req("sw", 1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 0, -1, 0, 0, 0);
    check("sw/cs", {31'd0, f_cs_dm, f_dm_we}, 33'd3);
    check("sw/mask", {29'd0, f_dm_mask}, 33'hF);
    check("sw/addr", {1'b0, f_dm_addr}, 33'h10);
    check("sw/wdata", {1'b0, f_dm_wdata}, {1'b0, 32'hDEAD_BEEF});
    run_req("sb", 1, 32'h13, 32'h0000_00A5, 3'b000, 0, 0, -1, 0, 0, 0);
    check("sb/mask", {29'd0, f_dm_mask}, 33'h8);
    check("sb/wdata", {1'b0, f_dm_wdata}, {1'b0, 32'hA5A5_A5A5});
    run_req("sh", 1, 32'h12, 32'h1234_BEEF, 3'b001, 0, 0, -1, 0, 0, 0);
    check("sh/mask", {29'd0, f_dm_mask}, 33'hC);
    check("sh/wdata", {1'b0, f_dm_wdata}, {1'b0, 32'hBEEF_BEEF});

    // DM loads, back-to-back
    run_req("lb", 0, 32'h13, 0, 3'b000, 32'hA500_0000, 0, -1, 1, 0, 32'hFFFF_FFA5);
    check("lb/cs", {31'd0, f_cs_dm, f_dm_we}, 33'd2);
    check("lb/addr", {1'b0, f_dm_addr}, 33'h10);
    run_req("lbu", 0, 32'h13, 0, 3'b100, 32'hA500_0000, 0, -1, 1, 0, 32'h0000_00A5);
    run_req("lh", 0, 32'h12, 0, 3'b001, 32'h8001_0000, 0, -1, 1, 0, 32'hFFFF_8001);
    run_req("lhu", 0, 32'h12, 0, 3'b101, 32'h8001_0000, 0, -1, 1, 0, 32'h0000_8001);
    run_req("lw_top", 0, 32'hFFC, 0, 3'b010, 32'h1234_5678, 0, -1, 1, 0, 32'h1234_5678);
    check("lw_top/addr", {1'b0, f_dm_addr}, 33'hFFC);

    // faults
    run_req("lh_mis", 0, 32'h11, 0, 3'b001, 0, 0, -1, 0, 1, 0);
    check("lh_mis/cs", {31'd0, f_cs_dm, f_cs_uart}, 33'd0);
    run_req("lw_mis", 0, 32'h12, 0, 3'b010, 0, 0, -1, 0, 1, 0);
    run_req("unmap", 0, 32'h4000_0000, 0, 3'b010, 0, 0, -1, 0, 1, 0);
    run_req("dm_end", 0, 32'h1000, 0, 3'b010, 0, 0, -1, 0, 1, 0);
    run_req("uart_end", 0, 32'h8000_0010, 0, 3'b010, 0, 0, -1, 0, 1, 0);
    run_req("f3_011", 0, 32'h0, 0, 3'b011, 0, 0, -1, 0, 1, 0);
    run_req("f3_110", 1, 32'h4, 0, 3'b110, 0, 0, -1, 0, 1, 0);

    // UART
    run_req("usw", 1, 32'h8000_0004, 32'hCAFE_F00D, 3'b010, 0, 32'h5555_5555, 3, 3, 0, 0);
    check("usw/cs", {31'd0, f_cs_uart, f_uart_we}, 33'd3);
    check("usw/addr", {29'd0, f_uart_addr}, 33'h4);
    check("usw/wdata", {1'b0, f_uart_wdata}, {1'b0, 32'hCAFE_F00D});
    check("usw/held", {32'd0, held_ok}, 33'd1);
    run_req("ulw0", 0, 32'h8000_0000, 0, 3'b010, 0, 32'h0000_0041, 0, 0, 0, 32'h0000_0041);
    run_req("ulb", 0, 32'h8000_0001, 0, 3'b000, 0, 32'h1234_5680, 1, 1, 0, 32'h1234_5680);
    run_req("utmo", 0, 32'h8000_0000, 0, 3'b010, 0, 32'hFFFF_FFFF, -1, TIMEOUT, 1, 0);
    check("utmo/cs_drop", {32'd0, e_cs_uart}, 33'd0);
    check("utmo/held", {32'd0, held_ok}, 33'd1);
    run_req("uedge", 0, 32'h8000_0008, 0, 3'b010, 0, 32'h0BAD_F00D, TIMEOUT, TIMEOUT, 0,
            32'h0BAD_F00D);
    idle_check("idle/after_uart");

    // reset during UART_WAIT aborts without a response
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h8000_0000;
    req_funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst/outs", {30'd0, cs_uart, stall, resp_valid}, 33'd0);
    check("mid_rst/state", {31'd0, dbg_state}, 33'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_req("post_rst", 0, 32'h20, 0, 3'b010, 32'h7777_1111, 0, -1, 1, 0, 32'h7777_1111);

    // random DM traffic, back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] a, d, w;
      logic        we;
      int          k;
      k  = $urandom_range(0, 4);
      we = 1'($urandom_range(0, 1));
      case (k)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if (we && f3[2]) f3 = {1'b0, f3[1:0]};
      case (f3[1:0])
        2'b00:   off = 2'($urandom_range(0, 3));
        2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
        default: off = 2'b00;
      endcase
      a = {20'd0, 10'($urandom_range(0, 1023)), off};
      d = $urandom;
      w = $urandom;
      if (we) begin
        run_req("rnd_st", 1, a, d, f3, 0, 0, -1, 0, 0, 0);
        check("rnd_st/mask", {29'd0, f_dm_mask}, {29'd0, st_mask(f3, off)});
        check("rnd_st/wdata", {1'b0, f_dm_wdata}, {1'b0, st_data(f3, d)});
      end else begin
        run_req("rnd_ld", 0, a, 0, f3, w, 0, -1, 1, 0, fmt_load(f3, off, w));
      end
      check("rnd/addr", {1'b0, f_dm_addr}, {1'b0, a[31:2], 2'b00});
    end
    idle_check("idle/end");

    check("sb/empty", 33'(exp_q.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
